gcode_exec_unit: RTL and testbench

Parametrised G-code execution unit, and the next generation of the printer's command controller. It sits between the G-code command decoder and the motion, heater and fan drivers. It accepts one decoded command at a time over a valid/ready handshake and converts absolute or relative targets into signed per-axis deltas. It then dispatches to the stepper, heater or fan logic, waits for completion (with hold-off and timeout), and returns a single done/error response. Axis count, heater count, data width and all wait durations are parameters.

---
 rtl/gcode_exec_unit_if.sv | 36 +++
 rtl/gcode_exec_unit.sv | 216 +++++++++++++++++++++
 tb/tb_gcode_exec_unit.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/gcode_exec_unit_if.sv
// rtl/gcode_exec_unit_if.sv - command, dispatch and response signals of the G-code execution unit
interface gcode_exec_unit_if #(
  parameter int N_AXES    = 5,
  parameter int N_HEATERS = 3,
  parameter int W         = 32
);
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic [31:0]            cmd_type;
  logic [N_AXES*W-1:0]    cmd_arg;
  logic [N_AXES*W-1:0]    pos;
  logic [N_AXES*W-1:0]    move_delta;
  logic                   move_start;
  logic                   move_done;
  logic [N_HEATERS-1:0]   heat_start;
  logic [N_HEATERS-1:0]   heat_long;
  logic [N_HEATERS-1:0]   heat_done;
  logic                   steppers_en;
  logic                   steppers_dis;
  logic                   fan_on;
  logic                   busy;
  logic                   done;
  logic                   error;

  modport master (
    output cmd_valid, cmd_type, cmd_arg, pos, move_done, heat_done,
    input  cmd_ready, move_delta, move_start, heat_start, heat_long,
           steppers_en, steppers_dis, fan_on, busy, done, error
  );

  modport slave (
    input  cmd_valid, cmd_type, cmd_arg, pos, move_done, heat_done,
    output cmd_ready, move_delta, move_start, heat_start, heat_long,
           steppers_en, steppers_dis, fan_on, busy, done, error
  );
endinterface

// File: rtl/gcode_exec_unit.sv
// rtl/gcode_exec_unit.sv - accepts one decoded G-code command, dispatches it to motion/heater/fan
// logic, waits for completion and returns a single done/error response
module gcode_exec_unit #(
  parameter int          N_AXES       = 5,
  parameter int          N_EXTR       = 2,
  parameter int          N_HEATERS    = 3,
  parameter int          W            = 32,
  parameter int          STEPPER_HOLD = 100,
  parameter int          HEAT_TIMEOUT = 0,
  parameter logic [31:0] GCODE_G0     = 32'd0,
  parameter logic [31:0] GCODE_G1     = 32'd1,
  parameter logic [31:0] GCODE_G90    = 32'd90,
  parameter logic [31:0] GCODE_G91    = 32'd91,
  parameter logic [31:0] GCODE_M17    = 32'd1017,
  parameter logic [31:0] GCODE_M18    = 32'd1018,
  parameter logic [31:0] GCODE_M82    = 32'd1082,
  parameter logic [31:0] GCODE_M83    = 32'd1083,
  parameter logic [31:0] GCODE_M104   = 32'd1104,
  parameter logic [31:0] GCODE_M106   = 32'd1106,
  parameter logic [31:0] GCODE_M107   = 32'd1107,
  parameter logic [31:0] GCODE_M109   = 32'd1109,
  parameter logic [31:0] GCODE_M140   = 32'd1140,
  parameter logic [31:0] GCODE_M190   = 32'd1190
) (
  input logic              clk,
  input logic              reset,
  gcode_exec_unit_if.slave bus
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_MOVE = 3'd1;
  localparam logic [2:0] ST_HEAT = 3'd2;
  localparam logic [2:0] ST_HOLD = 3'd3;
  localparam logic [2:0] ST_RESP = 3'd4;

  localparam int                E_LO      = N_AXES - N_EXTR;
  localparam logic [31:0]       HOLD_LAST = 32'(STEPPER_HOLD - 1);
  localparam logic [31:0]       HEAT_LIM  = 32'(HEAT_TIMEOUT);
  localparam logic signed [W-1:0] N_HEAT_S = W'(N_HEATERS);

  logic [2:0]            state_q, state_d;
  logic                  abs_xyz_q, abs_xyz_d;
  logic                  abs_e_q, abs_e_d;
  logic                  fan_on_q, fan_on_d;
  logic                  err_q, err_d;
  logic                  fresh_q, fresh_d;
  logic [31:0]           cnt_q, cnt_d;
  logic [N_AXES*W-1:0]   move_delta_q, move_delta_d;
  logic                  move_start_q, move_start_d;
  logic                  steppers_en_q, steppers_en_d;
  logic                  steppers_dis_q, steppers_dis_d;
  logic [N_HEATERS-1:0]  heat_start_q, heat_start_d;
  logic [N_HEATERS-1:0]  heat_long_q, heat_long_d;
  logic [N_HEATERS-1:0]  heat_sel_q, heat_sel_d;

  logic                  ready;
  logic                  accept;
  logic signed [W-1:0]   idx;
  logic                  idx_ok;
  logic [N_HEATERS-1:0]  idx_hot;
  logic [N_AXES*W-1:0]   delta_calc;
  logic                  heat_hit;

  assign ready    = (state_q == ST_IDLE) && !reset;
  assign accept   = bus.cmd_valid && ready;
  assign idx      = $signed(bus.cmd_arg[W-1:0]);
  assign idx_ok   = !idx[W-1] && (idx < N_HEAT_S);
  assign heat_hit = |(bus.heat_done & heat_sel_q);

  always_comb begin
    idx_hot = '0;
    for (int h = 0; h < N_HEATERS; h++) begin
      idx_hot[h] = idx_ok && (bus.cmd_arg[W-1:0] == W'(h));
    end
  end

  // Extruder lanes sit at the top of the bus and follow the E mode; the rest follow XYZ.
  always_comb begin
    logic lane_abs;
    delta_calc = '0;
    lane_abs   = 1'b0;
    for (int i = 0; i < N_AXES; i++) begin
      lane_abs = (i >= E_LO) ? abs_e_q : abs_xyz_q;
      delta_calc[i*W +: W] = lane_abs ? (bus.cmd_arg[i*W +: W] - bus.pos[i*W +: W])
                                      : bus.cmd_arg[i*W +: W];
    end
  end

  always_comb begin
    state_d        = state_q;
    abs_xyz_d      = abs_xyz_q;
    abs_e_d        = abs_e_q;
    fan_on_d       = fan_on_q;
    err_d          = err_q;
    fresh_d        = 1'b0;
    cnt_d          = cnt_q + 32'd1;
    move_delta_d   = move_delta_q;
    move_start_d   = 1'b0;
    steppers_en_d  = 1'b0;
    steppers_dis_d = 1'b0;
    heat_start_d   = '0;
    heat_long_d    = '0;
    heat_sel_d     = heat_sel_q;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (accept) begin
          fresh_d = 1'b1;
          err_d   = 1'b0;
          state_d = ST_RESP;
          case (bus.cmd_type)
            GCODE_G0, GCODE_G1: begin
              move_delta_d = delta_calc;
              move_start_d = 1'b1;
              state_d      = ST_MOVE;
            end
            GCODE_G90: abs_xyz_d = 1'b1;
            GCODE_G91: abs_xyz_d = 1'b0;
            GCODE_M82: abs_e_d   = 1'b1;
            GCODE_M83: abs_e_d   = 1'b0;
            GCODE_M17: begin
              steppers_en_d = 1'b1;
              state_d       = ST_HOLD;
            end
            GCODE_M18: begin
              steppers_dis_d = 1'b1;
              state_d        = ST_HOLD;
            end
            GCODE_M104, GCODE_M140: begin
              if (idx_ok) heat_start_d = idx_hot;
              else        err_d        = 1'b1;
            end
            GCODE_M109, GCODE_M190: begin
              if (idx_ok) begin
                heat_long_d = idx_hot;
                heat_sel_d  = idx_hot;
                state_d     = ST_HEAT;
              end else begin
                err_d = 1'b1;
              end
            end
            GCODE_M106: fan_on_d = 1'b1;
            GCODE_M107: fan_on_d = 1'b0;
            default:    err_d    = 1'b1;
          endcase
        end
      end
      // fresh_q marks the dispatch cycle, where completion levels left over from a previous command are ignored.
      ST_MOVE: begin
        if (!fresh_q && bus.move_done) state_d = ST_RESP;
      end
      ST_HEAT: begin
        if (!fresh_q && heat_hit) begin
          state_d = ST_RESP;
        end else if ((HEAT_TIMEOUT != 0) && (cnt_q == HEAT_LIM)) begin
          state_d = ST_RESP;
          err_d   = 1'b1;
        end
      end
      ST_HOLD: begin
        if (cnt_q == HOLD_LAST) state_d = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      abs_xyz_q      <= 1'b1;
      abs_e_q        <= 1'b1;
      fan_on_q       <= 1'b0;
      err_q          <= 1'b0;
      fresh_q        <= 1'b0;
      cnt_q          <= '0;
      move_delta_q   <= '0;
      move_start_q   <= 1'b0;
      steppers_en_q  <= 1'b0;
      steppers_dis_q <= 1'b0;
      heat_start_q   <= '0;
      heat_long_q    <= '0;
      heat_sel_q     <= '0;
    end else begin
      state_q        <= state_d;
      abs_xyz_q      <= abs_xyz_d;
      abs_e_q        <= abs_e_d;
      fan_on_q       <= fan_on_d;
      err_q          <= err_d;
      fresh_q        <= fresh_d;
      cnt_q          <= cnt_d;
      move_delta_q   <= move_delta_d;
      move_start_q   <= move_start_d;
      steppers_en_q  <= steppers_en_d;
      steppers_dis_q <= steppers_dis_d;
      heat_start_q   <= heat_start_d;
      heat_long_q    <= heat_long_d;
      heat_sel_q     <= heat_sel_d;
    end
  end

  // Pulses and done are masked by reset so an aborted command never leaks a response.
  assign bus.cmd_ready    = ready;
  assign bus.busy         = !ready;
  assign bus.move_delta   = move_delta_q;
  assign bus.move_start   = move_start_q && !reset;
  assign bus.steppers_en  = steppers_en_q && !reset;
  assign bus.steppers_dis = steppers_dis_q && !reset;
  assign bus.heat_start   = reset ? '0 : heat_start_q;
  assign bus.heat_long    = reset ? '0 : heat_long_q;
  assign bus.fan_on       = fan_on_q;
  assign bus.done         = (state_q == ST_RESP) && !reset;
  assign bus.error        = (state_q == ST_RESP) && !reset && err_q;

endmodule

// File: tb/tb_gcode_exec_unit.sv
// tb/tb_gcode_exec_unit.sv - vector table plus scoreboard bench for gcode_exec_unit
module tb_gcode_exec_unit;
  localparam int NA = 5;
  localparam int NH = 3;
  localparam int W  = 32;

  localparam logic [31:0] C_G0 = 32'd0, C_G1 = 32'd1, C_G90 = 32'd90, C_G91 = 32'd91;
  localparam logic [31:0] C_M17 = 32'd1017, C_M18 = 32'd1018, C_M82 = 32'd1082, C_M83 = 32'd1083;
  localparam logic [31:0] C_M104 = 32'd1104, C_M106 = 32'd1106, C_M107 = 32'd1107;
  localparam logic [31:0] C_M109 = 32'd1109, C_M140 = 32'd1140, C_M190 = 32'd1190;

  typedef logic [NA-1:0][W-1:0] lanes_t;
  localparam lanes_t Z = '0;

  typedef struct {
    logic [31:0]   code;
    lanes_t        arg;
    lanes_t        pos;
    int            ext;
    bit            stale;
    logic [NH-1:0] hdo;
    int            exp_done;
    bit            exp_err;
    bit            exp_mv;
    lanes_t        exp_delta;
    logic [NH-1:0] exp_hs;
    logic [NH-1:0] exp_hl;
    bit            exp_en;
    bit            exp_dis;
    bit            exp_fan;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  gcode_exec_unit_if #(.N_AXES(NA), .N_HEATERS(NH), .W(W)) bus ();

  gcode_exec_unit #(
    .N_AXES(NA), .N_EXTR(2), .N_HEATERS(NH), .W(W),
    .STEPPER_HOLD(100), .HEAT_TIMEOUT(20)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t vt[$];
  vec_t sb[$];

  function automatic lanes_t L(int a, int b, int c, int d, int e);
    lanes_t r;
    r[0] = a; r[1] = b; r[2] = c; r[3] = d; r[4] = e;
    return r;
  endfunction

  function automatic vec_t mk(logic [31:0] code, lanes_t arg, lanes_t pos, int ext, bit stale,
                              logic [NH-1:0] hdo, int dn, bit er, bit mv, lanes_t dl,
                              logic [NH-1:0] hs, logic [NH-1:0] hl, bit en, bit dis, bit fan);
    vec_t v;
    v.code = code; v.arg = arg; v.pos = pos; v.ext = ext; v.stale = stale; v.hdo = hdo;
    v.exp_done = dn; v.exp_err = er; v.exp_mv = mv; v.exp_delta = dl;
    v.exp_hs = hs; v.exp_hl = hl; v.exp_en = en; v.exp_dis = dis; v.exp_fan = fan;
    return v;
  endfunction

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  function automatic logic [8:0] pulses();
    return {bus.move_start, bus.heat_start, bus.heat_long, bus.steppers_en, bus.steppers_dis};
  endfunction

  task automatic run_vec(input vec_t v, input string tag);
    int            cyc;
    int            idx;
    bit            got;
    bit            hit;
    bit            is_mv;
    bit            is_wait;
    logic [NH-1:0] sel;
    vec_t          e;
    is_mv   = (v.code == C_G0) || (v.code == C_G1);
    is_wait = (v.code == C_M109) || (v.code == C_M190);
    idx     = int'($signed(v.arg[0]));
    sel     = '0;
    if (idx >= 0 && idx < NH) sel[idx] = 1'b1;
    for (int k = 0; k < 20 && !bus.cmd_ready; k++) @(negedge clk);
    if (!bus.cmd_ready) chk({tag, "/ready_before"}, 0, 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_type  = v.code;
    bus.cmd_arg   = v.arg;
    bus.pos       = v.pos;
    bus.move_done = is_mv && v.stale;
    bus.heat_done = v.hdo | ((is_wait && v.stale) ? sel : '0);
    sb.push_back(v);
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 400) begin
      @(negedge clk);
      cyc++;
      bus.cmd_valid = 1'b0;
      bus.cmd_arg   = {NA{$urandom}};
      bus.pos       = {NA{$urandom}};
      hit = (v.stale && cyc == 1) || (cyc == v.ext);
      bus.move_done = is_mv && hit;
      bus.heat_done = v.hdo | ((is_wait && hit) ? sel : '0);
      if (cyc == 1) begin
        chk({tag, "/pulses_c1"}, pulses(), {v.exp_mv, v.exp_hs, v.exp_hl, v.exp_en, v.exp_dis});
        chk({tag, "/fan_c1"}, bus.fan_on, v.exp_fan);
      end
      if (cyc == 2) chk({tag, "/pulses_c2"}, pulses(), 0);
      if (bus.error && !bus.done) chk({tag, "/error_without_done"}, 1, 0);
      if (bus.done && sb.size() > 0) begin
        e = sb.pop_front();
        chk({tag, "/done_cycle"}, cyc, e.exp_done);
        chk({tag, "/error"}, bus.error, e.exp_err);
        if (e.exp_mv) begin
          for (int i = 0; i < NA; i++)
            chk($sformatf("%s/delta%0d", tag, i), $signed(bus.move_delta[i*W +: W]),
                $signed(e.exp_delta[i]));
        end
        got = 1'b1;
      end
    end
    if (!got) begin
      chk({tag, "/done_timeout"}, cyc, v.exp_done);
      if (sb.size() > 0) void'(sb.pop_front());
    end
    @(negedge clk);
    bus.move_done = 1'b0;
    bus.heat_done = '0;
    chk({tag, "/after_done"}, {bus.done, bus.cmd_ready, pulses()}, {2'b01, 9'd0});
  endtask

  task automatic run_m17_hold();
    int   en_cnt;
    int   early;
    vec_t e;
    en_cnt = 0;
    early  = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_type  = C_M17;
    bus.cmd_arg   = Z;
    sb.push_back(mk(C_M17, Z, Z, 0, 0, 0, 101, 0, 0, Z, 0, 0, 1, 0, 0));
    for (int cyc = 1; cyc <= 102; cyc++) begin
      @(negedge clk);
      if (cyc == 1) chk("m17/en_c1", bus.steppers_en, 1);
      if (bus.steppers_en) en_cnt++;
      if (cyc < 102 && bus.cmd_ready) early++;
      if (bus.done && sb.size() > 0) begin
        e = sb.pop_front();
        chk("m17/done_cycle", cyc, e.exp_done);
        chk("m17/error", bus.error, e.exp_err);
      end
      if (cyc == 102) begin
        chk("m17/ready_c102", bus.cmd_ready, 1);
        bus.cmd_valid = 1'b0;
      end
    end
    chk("m17/done_seen", sb.size(), 0);
    chk("m17/en_pulses", en_cnt, 1);
    chk("m17/ready_while_busy", early, 0);
    sb.delete();
  endtask

  task automatic run_reset_abort();
    int n_done;
    n_done = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_type  = C_G1;
    bus.cmd_arg   = L(1, 2, 3, 4, 5);
    bus.pos       = L(9, 9, 9, 9, 9);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    chk("rst/move_start_c1", bus.move_start, 1);
    chk("rst/delta0_rel", $signed(bus.move_delta[W-1:0]), 1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    bus.move_done = 1'b1;
    @(negedge clk);
    chk("rst/outputs", {bus.done, bus.error, bus.cmd_ready, bus.fan_on, pulses()}, 0);
    chk("rst/busy", bus.busy, 1);
    chk("rst/move_delta", bus.move_delta, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst/ready_after_release", bus.cmd_ready, 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (bus.done) n_done++;
    end
    chk("rst/no_done", n_done, 0);
    bus.move_done = 1'b0;
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_type  = '0;
    bus.cmd_arg   = '0;
    bus.pos       = '0;
    bus.move_done = 1'b0;
    bus.heat_done = '0;
    repeat (3) @(negedge clk);
    chk("reset/ready", bus.cmd_ready, 0);
    chk("reset/outputs", {bus.done, bus.error, bus.fan_on, pulses()}, 0);
    chk("reset/move_delta", bus.move_delta, 0);
    reset = 1'b0;
    #1;
    chk("reset/ready_release", {bus.cmd_ready, bus.busy}, 2'b10);

    vt.push_back(mk(C_G1, L(100, -50, 0, 10, 0), L(40, 20, 0, -5, 0), 5, 0, 0, 6, 0, 1,
                    L(60, -70, 0, 15, 0), 0, 0, 0, 0, 0));
    vt.push_back(mk(C_G0, L(32'h7fff_ffff, 32'h8000_0000, 0, 0, 0), L(-1, 1, 0, 0, 0), 2, 1, 0, 3, 0, 1,
                    L(32'h8000_0000, 32'h7fff_ffff, 0, 0, 0), 0, 0, 0, 0, 0));
    vt.push_back(mk(C_G91, Z, Z, 0, 0, 0, 1, 0, 0, Z, 0, 0, 0, 0, 0));
    vt.push_back(mk(C_M83, Z, Z, 0, 0, 0, 1, 0, 0, Z, 0, 0, 0, 0, 0));
    vt.push_back(mk(C_G1, L(-7, 0, 0, 3, 9), L(1000, 5, 5, 5, 5), 2, 0, 0, 3, 0, 1,
                    L(-7, 0, 0, 3, 9), 0, 0, 0, 0, 0));
    vt.push_back(mk(C_G90, Z, Z, 0, 0, 0, 1, 0, 0, Z, 0, 0, 0, 0, 0));
    vt.push_back(mk(C_G1, L(5, 5, 5, 5, 5), L(1, 2, 3, 4, 6), 4, 0, 0, 5, 0, 1,
                    L(4, 3, 2, 5, 5), 0, 0, 0, 0, 0));
    vt.push_back(mk(C_M82, Z, Z, 0, 0, 0, 1, 0, 0, Z, 0, 0, 0, 0, 0));
    vt.push_back(mk(C_M109, L(1, 0, 0, 0, 0), Z, 0, 0, 3'b101, 22, 1, 0, Z, 0, 3'b010, 0, 0, 0));
    vt.push_back(mk(C_M109, L(1, 0, 0, 0, 0), Z, 9, 1, 0, 10, 0, 0, Z, 0, 3'b010, 0, 0, 0));
    vt.push_back(mk(C_M190, L(2, 0, 0, 0, 0), Z, 2, 0, 0, 3, 0, 0, Z, 0, 3'b100, 0, 0, 0));
    vt.push_back(mk(C_M104, L(3, 0, 0, 0, 0), Z, 0, 0, 0, 1, 1, 0, Z, 0, 0, 0, 0, 0));
    vt.push_back(mk(C_M104, L(0, 0, 0, 0, 0), Z, 0, 0, 0, 1, 0, 0, Z, 3'b001, 0, 0, 0, 0));
    vt.push_back(mk(C_M140, L(-1, 0, 0, 0, 0), Z, 0, 0, 0, 1, 1, 0, Z, 0, 0, 0, 0, 0));
    vt.push_back(mk(C_M190, L(3, 0, 0, 0, 0), Z, 0, 0, 0, 1, 1, 0, Z, 0, 0, 0, 0, 0));
    vt.push_back(mk(32'd555, Z, Z, 0, 0, 0, 1, 1, 0, Z, 0, 0, 0, 0, 0));
    vt.push_back(mk(C_M106, Z, Z, 0, 0, 0, 1, 0, 0, Z, 0, 0, 0, 0, 1));
    vt.push_back(mk(C_M107, Z, Z, 0, 0, 0, 1, 0, 0, Z, 0, 0, 0, 0, 0));
    vt.push_back(mk(C_M18, Z, Z, 0, 0, 0, 101, 0, 0, Z, 0, 0, 0, 1, 0));
    vt.push_back(mk(C_G91, Z, Z, 0, 0, 0, 1, 0, 0, Z, 0, 0, 0, 0, 0));
    vt.push_back(mk(C_M106, Z, Z, 0, 0, 0, 1, 0, 0, Z, 0, 0, 0, 0, 1));

    foreach (vt[i]) run_vec(vt[i], $sformatf("v%0d", i));

    run_m17_hold();
    run_reset_abort();
    run_vec(mk(C_G1, L(10, 10, 10, 10, 10), L(3, 3, 3, -2, 4), 3, 0, 0, 4, 0, 1,
               L(7, 7, 7, 12, 6), 0, 0, 0, 0, 0), "post_reset_abs");

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end
endmodule
